// File: rtl/gpio_ctrl_if.sv
// Word-addressed peripheral bus between the core and gpio_ctrl.
// Reads are combinational; writes commit on the clock edge with we=1.
interface gpio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata
  );
endinterface

// File: rtl/gpio_ctrl.sv
// WIDTH-pin GPIO block: DIR/OUT with atomic set/clr/toggle, synchronised
// inputs, per-pin edge detection into a W1C status and a level irq.
module gpio_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_ctrl_if.slave       bus,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam int R_DIR  = 0;
  localparam int R_OUT  = 1;
  localparam int R_IN   = 2;
  localparam int R_SET  = 3;
  localparam int R_CLR  = 4;
  localparam int R_TGL  = 5;
  localparam int R_IEN  = 6;
  localparam int R_REN  = 7;
  localparam int R_FEN  = 8;
  localparam int R_STAT = 9;

  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] ren_q;
  logic [WIDTH-1:0] fen_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       warm_q;
  logic             armed_q;

  logic [15:0]      sel;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd;
  logic             unused;

  assign sel    = 16'b1 << bus.addr[5:2];
  assign wd     = bus.wdata[WIDTH-1:0];
  assign in_w   = sync_q[SYNC_STAGES-1];
  assign unused = ^{bus.addr[31:6], bus.addr[1:0], bus.wdata, sel};

  // Events stay masked until the sync chain and prev hold real samples.
  always_comb begin
    evt = '0;
    if (armed_q) begin
      evt = (in_w & ~prev_q & ren_q)
          | (~in_w & prev_q & fen_q);
    end
  end

  always_comb begin
    w1c = '0;
    if (bus.we && sel[R_STAT]) begin
      w1c = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_q   <= '0;
      out_q   <= '0;
      ien_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      stat_q  <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
      armed_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= in_w;
      if (!armed_q) begin
        warm_q  <= warm_q + 3'd1;
        armed_q <= (warm_q == 3'(SYNC_STAGES));
      end
      // A new event on a bit beats a same-cycle clear of that bit.
      stat_q <= (stat_q & ~w1c) | evt;
      if (bus.we) begin
        unique case (1'b1)
          sel[R_DIR]: dir_q <= wd;
          sel[R_OUT]: out_q <= wd;
          sel[R_SET]: out_q <= out_q | wd;
          sel[R_CLR]: out_q <= out_q & ~wd;
          sel[R_TGL]: out_q <= out_q ^ wd;
          sel[R_IEN]: ien_q <= wd;
          sel[R_REN]: ren_q <= wd;
          sel[R_FEN]: fen_q <= wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel[R_DIR]:  rd = dir_q;
      sel[R_OUT]:  rd = out_q;
      sel[R_IN]:   rd = in_w;
      sel[R_IEN]:  rd = ien_q;
      sel[R_REN]:  rd = ren_q;
      sel[R_FEN]:  rd = fen_q;
      sel[R_STAT]: rd = stat_q;
      default:     rd = '0;
    endcase
  end

  assign bus.rdata = 32'(rd);
  assign gpio_out  = out_q;
  assign gpio_oe   = dir_q;
  assign irq       = |(stat_q & ien_q);

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised successor to the single-bank GPIO peripheral. It provides WIDTH pins with a per-pin output enable and atomic set/clear/toggle of the output register. Inputs pass through a configurable-depth synchroniser. Per-pin rising/falling edge detection feeds a sticky write-1-to-clear status register and a level interrupt. It sits on the core's word-addressed peripheral bus alongside the other memory-mapped devices.

## Interface
- WIDTH, 32, number of GPIO pins (1..32); register bits [31:WIDTH] read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (2..4)
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- addr  input  32  byte address; only addr[5:2] decoded, other bits ignored
- wdata  input  32  write data
- we  input  1  write strobe, one write per cycle
- rdata  output  32  read data, combinational from addr
- gpio_out  output  WIDTH  output data register (OUT)
- gpio_oe  output  WIDTH  output enable (DIR); 1 = pin driven
- gpio_in  input  WIDTH  asynchronous pin inputs
- irq  output  1  level interrupt = |(STATUS & IRQ_EN)

## Operation
- Register map (offset: name, access):
  - 0x00: DIR, RW
  - 0x04: OUT, RW
  - 0x08: IN, RO
  - 0x0C: OUT_SET, WO; OUT |= wdata
  - 0x10: OUT_CLR, WO; OUT &= ~wdata
  - 0x14: OUT_TGL, WO; OUT ^= wdata
  - 0x18: IRQ_EN, RW
  - 0x1C: RISE_EN, RW
  - 0x20: FALL_EN, RW
  - 0x24: STATUS, RW1C
- Write-only registers read 0. Offsets 0x28–0x3C read 0; writes to them are ignored.
- Input path: gpio_in → SYNC_STAGES flops (sync) → prev flop. IN reads the last sync stage. Pins with DIR=1 are still sampled, so IN reads back the driven value.
- Edge events:
  - rise = sync & ~prev & RISE_EN
  - fall = ~sync & prev & FALL_EN
  - event = (rise | fall) & armed
- STATUS bit sets on event regardless of IRQ_EN. STATUS bit clears when written with 1 at 0x24.
- Same bit set by an event and cleared by W1C in the same cycle: set wins, and STATUS stays 1.
- Warm-up: a counter runs from reset release. armed goes to 1 only after SYNC_STAGES+1 cycles, so pins held high through reset produce no spurious rising event.
- Reset values (all zero):
  - DIR, OUT, IRQ_EN, RISE_EN, FALL_EN, STATUS, sync chain, prev and armed all reset to 0.
  - Therefore gpio_out=0, gpio_oe=0 and irq=0 during reset and on the first cycle after it.
- Reset asserted mid-operation clears all of the above at the next edge. Pending STATUS is lost and warm-up restarts.

## Timing
- Reads: rdata valid in the same cycle as addr, with no wait states.
- Writes: take effect at the clk edge where we=1. gpio_out/gpio_oe change immediately after that edge.
- Input latency: a gpio_in change captured at edge k appears in IN after edge k+SYNC_STAGES−1.
- Event latency: STATUS sets at edge k+SYNC_STAGES. irq rises combinationally right after that edge, provided IRQ_EN is set.
- Clear latency: a W1C at edge m drops STATUS and irq after edge m, unless a new event on the same bit lands in that cycle.
- Pulse width: a pin pulse shorter than one clk period may be missed. No debounce is provided.
- Enable timing: writing IRQ_EN with a pending STATUS bit asserts irq immediately after that edge.

## Test plan
- Reset, then read all registers:
  - every register reads 0x0000_0000
  - gpio_out=0, gpio_oe=0, irq=0
  - with gpio_in=all-ones held through reset, STATUS is still 0 after 10 cycles
- Output updates:
  - write OUT=0x0000_00F0, OUT_SET=0x0F, OUT_CLR=0x30, OUT_TGL=0x1_0001
  - gpio_out reads back 0xF0, 0xFF, 0xCF, 0x1_00CE in turn, each visible the cycle after its write
  - reads of 0x0C/0x10/0x14 return 0
- Input sync (SYNC_STAGES=2): drive gpio_in[3] 0→1 at edge k → IN[3]=1 after edge k+1, not before.
- Rising-edge interrupt:
  - RISE_EN=0x8, IRQ_EN=0x8; pulse gpio_in[3] high for 3 cycles → STATUS=0x8 and irq=1 at edge k+2
  - falling edge causes no new event
  - W1C 0x8 → STATUS=0, irq=0
- Collision: a rising event on bit 0 lands in the same cycle as a W1C of bit 0 → STATUS[0] remains 1.
- WIDTH=8 instance:
  - write DIR=0xFFFF_FFFF → reads 0x0000_00FF
  - write to 0x28 → no register changes and the read returns 0
